// File: rtl/imm_pkg.sv
// Shared types for the immediate-extension pipeline: ImmSrc encoding and
// the stage-A payload carried between the decode and extend stages.
// No logic here; types and constants only.
package imm_pkg;

   localparam int IMM_INSTR_W = 24;

   typedef enum logic [1:0] {
      IMM_ROT8 = 2'b00,   // ARM 8-bit immediate rotated right by 2*rot4
      IMM_Z12  = 2'b01,   // 12-bit zero-extended offset
      IMM_BR24 = 2'b10,   // 24-bit signed branch offset
      IMM_HALF = 2'b11    // split halfword offset (optional)
   } imm_src_e;

   // Decoded entry held in stage A; rot is the full right-rotate amount.
   typedef struct packed {
      imm_src_e               src;
      logic [IMM_INSTR_W-1:0] instr;
      logic [4:0]             rot;
      logic                   carry;
   } imm_a_t;

endpackage

// File: rtl/imm_ror32.sv
// Purpose: 32-bit rotate right by 0..31, used by the extend stage.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module imm_ror32 (
   input  logic [31:0] din,
   input  logic [4:0]  amt,
   output logic [31:0] dout
);

   // A left shift by 32 yields zero, so amt == 0 falls out naturally.
   assign dout = (din >> amt) | (din << (6'd32 - {1'b0, amt}));

endmodule

// File: rtl/imm_extend_pipe.sv
// Purpose: two-stage immediate extender (A: decode fields, B: rotate/extend).
// Latency: 2 cycles from input acceptance to out_valid when not stalled.
// Backpressure: valid/ready; in_ready = !A_valid || B advances, no loss.
// Build option: define IMM_EXT_HALFWORD_EN to support ImmSrc 11 (split halfword
// offset); otherwise ImmSrc 11 yields ExtImm 0 with ImmIllegal set.
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int BR_SHIFT = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [23:0]     Instr,
   input  logic [1:0]      ImmSrc,
   input  logic            carry_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ExtImm,
   output logic            ImmCarry,
   output logic            ImmIllegal
);

   logic            a_valid;
   logic            b_valid;
   logic            b_adv;
   imm_a_t          a_d;
   imm_a_t          a_q;
   logic [31:0]     rot_out;
   logic [XLEN-1:0] br_sext;
   logic [XLEN-1:0] b_ext;
   logic            b_carry;
   logic            b_illegal;

   assign b_adv     = !b_valid || out_ready;
   assign in_ready  = !a_valid || b_adv;
   assign out_valid = b_valid;

   // Stage A decode: capture raw fields and derive the rotate amount.
   always_comb begin
      a_d       = '0;
      a_d.src   = imm_src_e'(ImmSrc);
      a_d.instr = Instr;
      a_d.rot   = {Instr[11:8], 1'b0};
      a_d.carry = carry_in;
   end

   // Valid bits: flush wins over everything, including a same-cycle input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_valid <= 1'b0;
         b_valid <= 1'b0;
      end else if (flush) begin
         a_valid <= 1'b0;
         b_valid <= 1'b0;
      end else begin
         if (b_adv)    b_valid <= a_valid;
         if (in_ready) a_valid <= in_valid;
      end
   end

   // Stage A payload: loads only on acceptance so carry_in is sampled then.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                  a_q <= '0;
      else if (in_ready && in_valid) a_q <= a_d;
   end

   imm_ror32 u_ror (
      .din  ({24'd0, a_q.instr[7:0]}),
      .amt  (a_q.rot),
      .dout (rot_out)
   );

   // Size cast of a signed operand sign-fills; the shift drops high bits.
   assign br_sext = XLEN'($signed(a_q.instr));

   // Stage B result selection by immediate mode.
   always_comb begin
      b_ext     = '0;
      b_carry   = a_q.carry;
      b_illegal = 1'b0;
      case (a_q.src)
         IMM_ROT8: begin
            b_ext[31:0] = rot_out;
            if (a_q.rot != 5'd0) b_carry = rot_out[31];
         end
         IMM_Z12:  b_ext[11:0] = a_q.instr[11:0];
         IMM_BR24: b_ext = br_sext << BR_SHIFT;
         IMM_HALF: begin
`ifdef IMM_EXT_HALFWORD_EN
            b_ext[7:0] = {a_q.instr[11:8], a_q.instr[3:0]};
`else
            b_illegal  = 1'b1;
`endif
         end
         default: b_illegal = 1'b1;
      endcase
   end

   // Stage B output registers: update only when B advances with a new entry,
   // which keeps them frozen while the consumer stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ExtImm     <= '0;
         ImmCarry   <= 1'b0;
         ImmIllegal <= 1'b0;
      end else if (b_adv && a_valid) begin
         ExtImm     <= b_ext;
         ImmCarry   <= b_carry;
         ImmIllegal <= b_illegal;
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: driver pushes expected results on
// acceptance, a negedge monitor pops and compares on each output handshake.
module tb_imm_extend_pipe;

   localparam int XLEN     = 32;
   localparam int BR_SHIFT = 2;
   localparam logic [63:0] MASK = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                               : ((64'd1 << XLEN) - 64'd1);

   typedef struct packed {
      logic [63:0] ext;
      logic        carry;
      logic        ill;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [23:0]     Instr = '0;
   logic [1:0]      ImmSrc = '0;
   logic            carry_in = 1'b0;
   logic            flush = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] ExtImm;
   logic            ImmCarry;
   logic            ImmIllegal;

   int   total  = 0;
   int   passed = 0;
   exp_t sb[$];

   imm_extend_pipe #(.XLEN(XLEN), .BR_SHIFT(BR_SHIFT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .Instr      (Instr),
      .ImmSrc     (ImmSrc),
      .carry_in   (carry_in),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ExtImm     (ExtImm),
      .ImmCarry   (ImmCarry),
      .ImmIllegal (ImmIllegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model straight from the mode rules.
   function automatic exp_t model(input logic [1:0] src, input logic [23:0] ins, input logic cin);
      exp_t        e;
      logic [31:0] v;
      longint      s;
      int          r;
      e.ext = '0; e.carry = cin; e.ill = 1'b0;
      case (src)
         2'd0: begin
            v = {24'd0, ins[7:0]};
            r = 2 * int'(ins[11:8]);
            for (int k = 0; k < r; k++) v = {v[0], v[31:1]};
            e.ext = {32'd0, v};
            if (ins[11:8] != 4'd0) e.carry = v[31];
         end
         2'd1: e.ext = {52'd0, ins[11:0]};
         2'd2: begin
            s = longint'(ins);
            if (ins[23]) s = s - 64'sd16777216;
            s = s * (64'sd1 <<< BR_SHIFT);
            e.ext = 64'(s) & MASK;
         end
         default: begin
`ifdef IMM_EXT_HALFWORD_EN
            e.ext = {56'd0, ins[11:8], ins[3:0]};
`else
            e.ill = 1'b1;
`endif
         end
      endcase
      return e;
   endfunction

   function automatic exp_t mk(input logic [63:0] x, input logic c, input logic i);
      exp_t e;
      e.ext = x; e.carry = c; e.ill = i;
      return e;
   endfunction

   // Monitor: compare on handshake, and check hold-stability during stalls.
   logic            prev_stall = 1'b0;
   logic [XLEN-1:0] prev_ext;
   logic            prev_carry;
   logic            prev_ill;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && out_valid) begin
            chk("hold_ext", 64'(ExtImm), 64'(prev_ext));
            chk("hold_flags", {62'd0, ImmCarry, ImmIllegal}, {62'd0, prev_carry, prev_ill});
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("ext", 64'(ExtImm), e.ext);
               chk("carry", 64'(ImmCarry), 64'(e.carry));
               chk("illegal", 64'(ImmIllegal), 64'(e.ill));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_ext   = ExtImm;
         prev_carry = ImmCarry;
         prev_ill   = ImmIllegal;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one input for one cycle; push the given expectation if accepted.
   task automatic offer(input logic [1:0] s, input logic [23:0] i, input logic c,
                        input exp_t e, output bit acc);
      in_valid = 1'b1; ImmSrc = s; Instr = i; carry_in = c;
      #1;
      acc = in_ready && !flush;
      if (acc) sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 60 && (sb.size() != 0 || out_valid); k++) step();
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      bit acc;
      int n_acc;
      bit rdy3;
      logic [1:0]  s;
      logic [23:0] ins;
      logic        c;

      // Reset state.
      step(); step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_ext", 64'(ExtImm), 64'd0);
      reset_n = 1'b1;

      // Latency and first vector; first acceptance on first edge after reset.
      out_ready = 1'b1;
      offer(2'd0, 24'h0004FF, 1'b0, mk(64'hFF000000, 1'b1, 1'b0), acc);
      chk("first_accept", 64'(acc), 64'd1);
      in_valid = 1'b0;
      chk("lat_cycle1", 64'(out_valid), 64'd0);
      step();
      chk("lat_cycle2", 64'(out_valid), 64'd1);

      // Full-throughput back-to-back vectors.
      offer(2'd0, 24'h0000AB, 1'b1, mk(64'h000000AB, 1'b1, 1'b0), acc);
      chk("b2b_acc0", 64'(acc), 64'd1);
      offer(2'd2, 24'hFFFFFE, 1'b0, mk(64'hFFFFFFF8, 1'b0, 1'b0), acc);
      chk("b2b_acc1", 64'(acc), 64'd1);
`ifdef IMM_EXT_HALFWORD_EN
      offer(2'd3, 24'h000A05, 1'b1, mk(64'h000000A5, 1'b1, 1'b0), acc);
`else
      offer(2'd3, 24'h000A05, 1'b1, mk(64'h0, 1'b1, 1'b1), acc);
`endif
      chk("b2b_acc2", 64'(acc), 64'd1);
      drain();

      // Backpressure: three offers with out_ready low, only two fit.
      out_ready = 1'b0;
      n_acc = 0;
      for (int k = 0; k < 3; k++) begin
         s = 2'($urandom_range(0, 2)); ins = 24'($urandom); c = 1'($urandom);
         in_valid = 1'b1; ImmSrc = s; Instr = ins; carry_in = c;
         #1;
         if (k == 2) rdy3 = in_ready;
         if (in_ready) begin
            sb.push_back(model(s, ins, c));
            n_acc++;
         end
         step();
      end
      in_valid = 1'b0;
      chk("bp_accepted", 64'(n_acc), 64'd2);
      chk("bp_ready3", 64'(rdy3), 64'd0);
      repeat (3) step();
      drain();

      // Flush with two entries in flight and a third offered.
      out_ready = 1'b0;
      offer(2'd1, 24'h000123, 1'b0, model(2'd1, 24'h000123, 1'b0), acc);
      offer(2'd0, 24'h0004FF, 1'b1, model(2'd0, 24'h0004FF, 1'b1), acc);
      in_valid = 1'b1; Instr = 24'h000777; ImmSrc = 2'd1; flush = 1'b1;
      sb.delete();
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      repeat (5) step();
      chk("flush_no_stale", 64'(out_valid), 64'd0);

      // Randomized traffic against the model.
      for (int k = 0; k < 400; k++) begin
         s = 2'($urandom); ins = 24'($urandom); c = 1'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         ImmSrc = s; Instr = ins; carry_in = c;
         #1;
         if (in_valid && in_ready) sb.push_back(model(s, ins, c));
         step();
      end
      drain();

      // Reset mid-stream: outputs clear immediately.
      out_ready = 1'b0;
      offer(2'd0, 24'h0004FF, 1'b1, model(2'd0, 24'h0004FF, 1'b1), acc);
      offer(2'd0, 24'h0004FF, 1'b1, model(2'd0, 24'h0004FF, 1'b1), acc);
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      sb.delete();
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_ext", 64'(ExtImm), 64'd0);
      chk("mid_rst_flags", {62'd0, ImmCarry, ImmIllegal}, 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      step();
      reset_n = 1'b1;
      out_ready = 1'b1;
      offer(2'd1, 24'h000FFF, 1'b0, mk(64'h00000FFF, 1'b0, 1'b0), acc);
      chk("post_rst_accept", 64'(acc), 64'd1);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
